// File: rtl/present_enc_sched_if.sv
// Handshake bundle for the serialized PRESENT-80 encryptor: plaintext/key in, ciphertext out.
// No logic here; latency is defined entirely by the attached controller.
// Back-pressure: in_ready / out_ready close the valid/ready loops on each side.
interface present_enc_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ciphertext;
  logic        busy;

  // Source/sink side (drives offers, consumes results)
  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  // Encryptor side
  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/present_enc_sched.sv
// Serialized PRESENT-80 encryptor: one time-shared S-box covers the state nibbles and the key-schedule nibble.
// Latency: out_valid rises 19*ROUNDS+1 edges after accept (11*ROUNDS+1 with PRESENT_SBOX_DUAL_EN, two S-box lanes).
// Back-pressure: accepts only in IDLE; DONE holds ciphertext constant until out_ready.

module present_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // PRESENT 4-bit substitution table
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end
endmodule

module present_enc_sched #(
  parameter int ROUNDS = 31
) (
  input logic                 clk,
  input logic                 rst_n,
  present_enc_sched_if.slave  bus
);

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);
`ifdef PRESENT_SBOX_DUAL_EN
  localparam logic [3:0] NC_LAST = 4'd7;
`else
  localparam logic [3:0] NC_LAST = 4'd15;
`endif

  typedef enum logic [2:0] {
    st_idle,
    st_addkey,
    st_sbox,
    st_player,
    st_keyupd,
    st_final,
    st_done
  } fsm_t;

  fsm_t        cur;
  fsm_t        nxt;
  logic [63:0] state;
  logic [79:0] key_r;
  logic [4:0]  rc;
  logic [3:0]  nc;

  logic [79:0] key_rot;
  logic [63:0] perm;
  logic [3:0]  sb0_in;
  logic [3:0]  sb0_out;

  // Key register rotated left by 61 (equivalently right by 19)
  assign key_rot = {key_r[18:0], key_r[79:19]};

  // Bit-permutation layer: bit i lands on (16*i) mod 63, bit 63 is fixed
  always_comb begin
    perm = '0;
    for (int i = 0; i < 63; i++) begin
      perm[(16 * i) % 63] = state[i];
    end
    perm[63] = state[63];
  end

  // Lane-0 S-box input: key nibble during KEYUPD, otherwise the current state nibble
  always_comb begin
`ifdef PRESENT_SBOX_DUAL_EN
    sb0_in = state[{nc[2:0], 3'b000} +: 4];
`else
    sb0_in = state[{nc, 2'b00} +: 4];
`endif
    if (cur == st_keyupd) begin
      sb0_in = key_rot[79:76];
    end
  end

  present_sbox u_sbox0 (
    .din  (sb0_in),
    .dout (sb0_out)
  );

`ifdef PRESENT_SBOX_DUAL_EN
  logic [3:0] sb1_in;
  logic [3:0] sb1_out;

  // Lane 1 only ever serves the odd nibble of the pair
  assign sb1_in = state[{nc[2:0], 3'b100} +: 4];

  present_sbox u_sbox1 (
    .din  (sb1_in),
    .dout (sb1_out)
  );
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= st_idle;
    end else begin
      cur <= nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    nxt = cur;
    case (cur)
      st_idle:   if (bus.in_valid) nxt = st_addkey;
      st_addkey: nxt = st_sbox;
      st_sbox:   if (nc == NC_LAST) nxt = st_player;
      st_player: nxt = st_keyupd;
      st_keyupd: nxt = (rc == RC_LAST) ? st_final : st_addkey;
      st_final:  nxt = st_done;
      st_done:   if (bus.out_ready) nxt = st_idle;
      default:   nxt = st_idle;
    endcase
  end

  // Datapath: cipher state, key schedule and counters, sequenced by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      key_r <= '0;
      rc    <= '0;
      nc    <= '0;
    end else begin
      case (cur)
        st_idle: begin
          if (bus.in_valid) begin
            state <= bus.plaintext;
            key_r <= bus.key;
            rc    <= 5'd1;
            nc    <= 4'd0;
          end
        end
        st_addkey: begin
          state <= state ^ key_r[79:16];
          nc    <= 4'd0;
        end
        st_sbox: begin
`ifdef PRESENT_SBOX_DUAL_EN
          state[{nc[2:0], 3'b000} +: 4] <= sb0_out;
          state[{nc[2:0], 3'b100} +: 4] <= sb1_out;
`else
          state[{nc, 2'b00} +: 4] <= sb0_out;
`endif
          nc <= nc + 4'd1;
        end
        st_player: begin
          state <= perm;
        end
        st_keyupd: begin
          key_r <= {sb0_out, key_rot[75:20], key_rot[19:15] ^ rc, key_rot[14:0]};
          if (rc != RC_LAST) begin
            rc <= rc + 5'd1;
          end
        end
        st_final: begin
          state <= state ^ key_r[79:16];
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decode registered state only
  assign bus.in_ready   = (cur == st_idle);
  assign bus.out_valid  = (cur == st_done);
  assign bus.busy       = (cur != st_idle);
  assign bus.ciphertext = state;

endmodule

// File: tb/tb_present_enc_sched.sv
// Self-checking bench for present_enc_sched: known-answer vectors, latency, back-pressure,
// mid-run reset and back-to-back streaming, with a queue of expected ciphertexts.
module tb_present_enc_sched;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

`ifdef PRESENT_SBOX_DUAL_EN
  localparam int LAT = 342;
`else
  localparam int LAT = 590;
`endif
  localparam int PERIOD = LAT + 2;
  localparam int BOUND  = 2000;

  present_enc_sched_if bus ();

  present_enc_sched #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  logic [63:0] vec_pt  [4] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [79:0] vec_key [4] = '{80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
  logic [63:0] vec_ct  [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                               64'hA112FFC72F68417B, 64'h3333DCD3213210D2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block and wait (bounded) for it to be accepted; queue its expected result
  task automatic send(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp_ct);
    int n;
    n = 0;
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    tick();
    sb.push_back(exp_ct);
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen (bounded)
  task automatic wait_out(output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < BOUND) begin
      tick();
      edges++;
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    e = 64'hx;
    if (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.ciphertext !== 64'h0) begin errors++; $display("FAIL reset_ciphertext: got %h, required 0", bus.ciphertext); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: in_ready=%b, required 1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    int edges;
    logic [63:0] e;
    for (int v = 0; v < 3; v++) begin
      send(vec_pt[v], vec_key[v], vec_ct[v]);
      wait_out(edges);
      pop_exp(e);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_timeout: out_valid=%b, required 1", v, bus.out_valid); end
      checks++; if (edges !== LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d edges, required %0d", v, edges, LAT); end
      checks++; if (bus.ciphertext !== e) begin errors++; $display("FAIL vec%0d_ct: got %h, required %h", v, bus.ciphertext, e); end
      drain();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL vec%0d_release: out_valid=%b in_ready=%b, required 0/1", v, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int edges;
    logic [63:0] e;
    send(vec_pt[3], vec_key[3], vec_ct[3]);
    wait_out(edges);
    pop_exp(e);
    checks++; if (edges !== LAT) begin errors++; $display("FAIL bp_latency: got %0d edges, required %0d", edges, LAT); end
    for (int i = 0; i < 50; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", i, bus.out_valid); end
      checks++; if (bus.ciphertext !== e) begin errors++; $display("FAIL bp_ct[%0d]: got %h, required %h", i, bus.ciphertext, e); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, bus.in_ready); end
      if (i == 20) begin
        bus.plaintext = 64'h0123_4567_89AB_CDEF;
        bus.key       = 80'h1;
        bus.in_valid  = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    drain();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b, required 1", bus.in_ready); end
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_no_capture: busy=%b, required 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int edges;
    logic [63:0] e;
    send(vec_pt[0], vec_key[0], vec_ct[0]);
    repeat (299) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b, required 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b, required 1", bus.in_ready); end
    checks++; if (bus.ciphertext !== 64'h0) begin errors++; $display("FAIL mid_ct: got %h, required 0", bus.ciphertext); end
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(vec_pt[0], vec_key[0], vec_ct[0]);
    wait_out(edges);
    pop_exp(e);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_timeout: out_valid=%b, required 1", bus.out_valid); end
    checks++; if (bus.ciphertext !== e) begin errors++; $display("FAIL mid_restart_ct: got %h, required %h", bus.ciphertext, e); end
    drain();
  endtask

  task automatic test_back_to_back();
    int cyc;
    int nacc;
    int nout;
    int acc_at [2];
    logic [63:0] e;
    cyc = 0; nacc = 0; nout = 0;
    acc_at[0] = 0; acc_at[1] = 0;
    bus.plaintext = vec_pt[0];
    bus.key       = vec_key[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (nout < 2 && cyc < 3 * PERIOD) begin
      if (bus.out_valid === 1'b1) begin
        pop_exp(e);
        checks++; if (bus.ciphertext !== e) begin errors++; $display("FAIL b2b_ct%0d: got %h, required %h", nout, bus.ciphertext, e); end
        nout++;
        if (nout == 2) bus.in_valid = 1'b0;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && nacc < 2) begin
        acc_at[nacc] = cyc;
        sb.push_back((nacc == 0) ? vec_ct[0] : vec_ct[3]);
        nacc++;
      end
      tick();
      cyc++;
      if (nacc >= 1) begin
        bus.plaintext = vec_pt[3];
        bus.key       = vec_key[3];
      end
    end
    bus.out_ready = 1'b0;
    checks++; if (nout !== 2) begin errors++; $display("FAIL b2b_outputs: got %0d, required 2", nout); end
    checks++; if (nacc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d, required 2", nacc); end
    checks++; if (acc_at[1] - acc_at[0] !== PERIOD) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles, required %0d", acc_at[1] - acc_at[0], PERIOD);
    end
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: busy=%b in_ready=%b, required 0/1", bus.busy, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
